qmf_subband_decim_axis: RTL and testbench
=========================================

QMF_SUBBAND_DECIM_AXIS -- requirements
Module: qmf_subband_decim_axis

Interface
REQ-001 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 12, AXI-Lite address width.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI-Lite data width.
REQ-003 SHALL have ports:
- clk  in  1  clock, all logic rising-edge.
- rstn  in  1  reset, synchronous, active-low.
- s_axis_low_tdata/tvalid/tready/tlast  in/in/out/in  32/1/1/1  low-band stereo input; [15:0]=L, [31:16]=R.
- s_axis_high_tdata/tvalid/tready/tlast  in/in/out/in  32/1/1/1  high-band stereo input, same packing.
- m_axis_tdata/tvalid/tready/tlast  out/out/in/out  32/1/1/1  decimated, gained subband beats.
- m_axis_tuser  out  1  band tag: 0=low, 1=high.
- s_axi_aw*/w*/b*/ar*/r*  AXI4-Lite slave: awaddr, awvalid, awready, wdata, wvalid, wready, bresp, bvalid, bready, araddr, arvalid, arready, rdata, rresp, rvalid, rready.

Function
REQ-004 SHALL map registers: 0x00 CTRL (bit0 en, bit1 phase_sel); 0x04 GAIN_LOW[15:0] signed Q1.15; 0x08 GAIN_HIGH[15:0] signed Q1.15; 0x0C FRAME_CNT 32b RO, any write clears; 0x10 STATUS bit0 sticky tlast_mismatch, write bit0=1 clears.
REQ-005 SHALL accept AXI-Lite write only when awvalid and wvalid both high: awready/wready pulse one cycle, bvalid next cycle, held until bready; bresp=OKAY.
REQ-006 SHALL answer AXI-Lite read with one-cycle arready pulse and rvalid held until rready; rresp=OKAY; unmapped reads return 0, unmapped writes ignored.
REQ-007 SHALL drive s_axis_low_tready and s_axis_high_tready from a single join_ready; a pair is consumed (fire) only when both tvalid and join_ready are high.
REQ-008 SHALL keep a 1-bit phase toggling on every fire; a fired pair is kept when phase==phase_sel, otherwise dropped.
REQ-009 SHALL reset phase to 0 after a fire carrying s_axis_low_tlast, and while en=0.
REQ-010 SHALL compute per channel: out = sat16((x * gain) >>> 15), 32-bit signed product, arithmetic shift (truncation), saturate to [-32768, 32767]; low lanes use GAIN_LOW, high lanes GAIN_HIGH; result registered at kept-pair capture.
REQ-011 SHALL implement FSM EMPTY/LOW/HIGH:
- EMPTY: m_axis_tvalid=0; kept fire -> load pair, go LOW.
- LOW: tvalid=1, tuser=0, tdata=low pair, tlast=0; on tready -> HIGH.
- HIGH: tvalid=1, tuser=1, tdata=high pair, tlast=pair_last; on tready -> LOW if kept fire same cycle (load), else EMPTY.
REQ-012 SHALL set join_ready = en and (EMPTY, or HIGH and m_axis_tready, or LOW and next fire is a drop phase); when en=0 join_ready=1 only in EMPTY (inputs discarded).
REQ-013 SHALL set pair_last from low tlast of kept pair; tlast of a dropped pair SHALL OR into pair_last if in LOW/HIGH, else set pending_last, which is ORed into the next loaded pair_last and then cleared.
REQ-014 SHALL hold tdata/tuser/tlast stable while tvalid=1 and tready=0.
REQ-015 SHALL set tlast_mismatch when a fire has s_axis_low_tlast != s_axis_high_tlast.
REQ-016 SHALL increment FRAME_CNT on each output beat with tvalid, tready and tlast; wraps 0xFFFFFFFF->0; clear wins over increment.
REQ-017 SHALL apply en=0 only in EMPTY; an in-flight pair completes both beats.
REQ-018 SHALL sustain one output beat per cycle with continuous valid inputs and tready=1; fire-to-first-beat latency 1 cycle.

Reset
REQ-019 SHALL on rstn=0: state EMPTY, m_axis_tvalid=0, tlast=0, tuser=0, tdata=0, phase=0, pending_last=0, en=0, phase_sel=0, gains=0x7FFF, FRAME_CNT=0, STATUS=0, all AXI-Lite valid/ready outputs 0.
REQ-020 SHALL abandon any in-flight pair on rstn=0, no beat emitted after reset.

Verification
REQ-021 Stream pairs 1..8 (L=R=k*1000), gains 0x7FFF, phase_sel=0 -> beats from pairs 1,3,5,7 as low,high; value 1000 -> 999; 1 beat/cycle.
REQ-022 phase_sel=1, GAIN_HIGH=0x4000, high input 0x2000 -> even pairs kept, high lanes 0x1000.
REQ-023 Low input 0x8000, GAIN_LOW=0x8000 -> 0x7FFF; input 0x7FFF, gain 0x8000 -> 0x8001.
REQ-024 tlast on dropped pair 4 -> tlast on high beat of pair 3; FRAME_CNT=1; next frame phase restarts at 0.
REQ-025 m_axis_tready toggling 1/0 random -> no loss/duplication, outputs stable under stall; low.tlast=1, high.tlast=0 -> STATUS=1.
REQ-026 rstn low during LOW beat -> next cycle tvalid=0, registers at reset values.

Source files
------------

// File: rtl/qmf_subband_decim_axis_if.sv
// Stream and AXI4-Lite bundle for the QMF subband decimator.
// slave is the decimator's own view; master is the view of whatever drives it.
interface qmf_subband_decim_axis_if #(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
);
    logic [31:0]                   s_axis_low_tdata;
    logic                          s_axis_low_tvalid;
    logic                          s_axis_low_tready;
    logic                          s_axis_low_tlast;
    logic [31:0]                   s_axis_high_tdata;
    logic                          s_axis_high_tvalid;
    logic                          s_axis_high_tready;
    logic                          s_axis_high_tlast;
    logic [31:0]                   m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tready;
    logic                          m_axis_tlast;
    logic                          m_axis_tuser;
    logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr;
    logic                          s_axi_awvalid;
    logic                          s_axi_awready;
    logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata;
    logic                          s_axi_wvalid;
    logic                          s_axi_wready;
    logic [1:0]                    s_axi_bresp;
    logic                          s_axi_bvalid;
    logic                          s_axi_bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr;
    logic                          s_axi_arvalid;
    logic                          s_axi_arready;
    logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata;
    logic [1:0]                    s_axi_rresp;
    logic                          s_axi_rvalid;
    logic                          s_axi_rready;

    modport slave (
        input  s_axis_low_tdata, s_axis_low_tvalid, s_axis_low_tlast,
        input  s_axis_high_tdata, s_axis_high_tvalid, s_axis_high_tlast,
        output s_axis_low_tready, s_axis_high_tready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        input  m_axis_tready,
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        input  s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axis_low_tdata, s_axis_low_tvalid, s_axis_low_tlast,
        output s_axis_high_tdata, s_axis_high_tvalid, s_axis_high_tlast,
        input  s_axis_low_tready, s_axis_high_tready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
        output m_axis_tready,
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wvalid, s_axi_bready,
        output s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/qmf_subband_decim_axis.sv
// 2:1 decimator for a low/high QMF stereo subband pair: keeps every other pair,
// applies a Q1.15 gain per band and emits each kept pair as a low beat then a high beat.
module qmf_subband_decim_axis #(
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    qmf_subband_decim_axis_if.slave bus
);
    typedef logic [C_S_AXI_ADDR_WIDTH-1:0] addr_t;
    localparam addr_t ADDR_CTRL      = addr_t'(32'h00);
    localparam addr_t ADDR_GAIN_LOW  = addr_t'(32'h04);
    localparam addr_t ADDR_GAIN_HIGH = addr_t'(32'h08);
    localparam addr_t ADDR_FRAME_CNT = addr_t'(32'h0C);
    localparam addr_t ADDR_STATUS    = addr_t'(32'h10);

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_LOW = 2'd1, ST_HIGH = 2'd2} state_t;

    function automatic logic [15:0] scale_sat(input logic [15:0] x, input logic [15:0] g);
        logic signed [31:0] prod;
        logic signed [31:0] shr;
        prod = $signed(x) * $signed(g);
        shr  = prod >>> 15;
        if (shr > 32'sd32767)       return 16'h7FFF;
        else if (shr < -32'sd32768) return 16'h8000;
        else                        return shr[15:0];
    endfunction

    function automatic logic [31:0] scale_pair(input logic [31:0] d, input logic [15:0] g);
        return {scale_sat(d[31:16], g), scale_sat(d[15:0], g)};
    endfunction

    state_t      state_r;
    logic        en_r, phase_sel_r, phase_r, pair_last_r, pending_last_r, mismatch_r;
    logic [15:0] gain_low_r, gain_high_r;
    logic [31:0] frame_cnt_r, high_pair_r, m_tdata_r;
    logic        m_tvalid_r, m_tuser_r, m_tlast_r;
    logic        awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_r, rdata_s;
    logic        join_ready_s, fire_s, keep_s, drop_last_s, load_s;
    logic        wr_en_s, rd_en_s, frame_clr_s, status_clr_s, unused_s;
    logic [31:0] low_scaled_s, high_scaled_s;

    assign fire_s        = bus.s_axis_low_tvalid && bus.s_axis_high_tvalid && join_ready_s;
    assign keep_s        = fire_s && en_r && (phase_r == phase_sel_r);
    assign drop_last_s   = fire_s && en_r && (phase_r != phase_sel_r) && bus.s_axis_low_tlast;
    assign load_s        = keep_s && ((state_r == ST_EMPTY) || ((state_r == ST_HIGH) && bus.m_axis_tready));
    assign low_scaled_s  = scale_pair(bus.s_axis_low_tdata, gain_low_r);
    assign high_scaled_s = scale_pair(bus.s_axis_high_tdata, gain_high_r);

    // Input join: a drop-phase pair may slip in while the low beat is still waiting.
    always_comb begin
        join_ready_s = 1'b0;
        case (state_r)
            ST_EMPTY: join_ready_s = 1'b1;
            ST_LOW:   join_ready_s = en_r && (phase_r != phase_sel_r);
            ST_HIGH:  join_ready_s = en_r && bus.m_axis_tready;
            default:  join_ready_s = 1'b0;
        endcase
    end

    // Output sequencer: registered low/high beats plus frame-boundary bookkeeping.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r        <= ST_EMPTY;
            m_tvalid_r     <= 1'b0;
            m_tuser_r      <= 1'b0;
            m_tlast_r      <= 1'b0;
            m_tdata_r      <= 32'h0;
            high_pair_r    <= 32'h0;
            pair_last_r    <= 1'b0;
            pending_last_r <= 1'b0;
            phase_r        <= 1'b0;
        end else begin
            if (!en_r)       phase_r <= 1'b0;
            else if (fire_s) phase_r <= bus.s_axis_low_tlast ? 1'b0 : ~phase_r;
            if (load_s) begin
                state_r        <= ST_LOW;
                m_tvalid_r     <= 1'b1;
                m_tuser_r      <= 1'b0;
                m_tlast_r      <= 1'b0;
                m_tdata_r      <= low_scaled_s;
                high_pair_r    <= high_scaled_s;
                pair_last_r    <= bus.s_axis_low_tlast | pending_last_r;
                pending_last_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_EMPTY: if (drop_last_s) pending_last_r <= 1'b1;
                    ST_LOW: begin
                        if (drop_last_s) pair_last_r <= 1'b1;
                        if (bus.m_axis_tready) begin
                            state_r   <= ST_HIGH;
                            m_tuser_r <= 1'b1;
                            m_tdata_r <= high_pair_r;
                            m_tlast_r <= pair_last_r | drop_last_s;
                        end
                    end
                    ST_HIGH: if (bus.m_axis_tready) begin
                        // the high beat leaves this cycle, so a dropped tlast belongs to the next pair
                        state_r    <= ST_EMPTY;
                        m_tvalid_r <= 1'b0;
                        m_tuser_r  <= 1'b0;
                        m_tlast_r  <= 1'b0;
                        if (drop_last_s) pending_last_r <= 1'b1;
                    end
                    default: begin
                        state_r    <= ST_EMPTY;
                        m_tvalid_r <= 1'b0;
                        m_tuser_r  <= 1'b0;
                        m_tlast_r  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign wr_en_s      = awready_r && bus.s_axi_awvalid && bus.s_axi_wvalid;
    assign rd_en_s      = arready_r && bus.s_axi_arvalid;
    assign frame_clr_s  = wr_en_s && (bus.s_axi_awaddr == ADDR_FRAME_CNT);
    assign status_clr_s = wr_en_s && (bus.s_axi_awaddr == ADDR_STATUS) && bus.s_axi_wdata[0];
    assign unused_s     = &{1'b0, bus.s_axi_wdata};

    // Register read mux; unmapped addresses read as zero.
    always_comb begin
        rdata_s = {C_S_AXI_DATA_WIDTH{1'b0}};
        case (bus.s_axi_araddr)
            ADDR_CTRL:      rdata_s = C_S_AXI_DATA_WIDTH'({30'h0, phase_sel_r, en_r});
            ADDR_GAIN_LOW:  rdata_s = C_S_AXI_DATA_WIDTH'({16'h0, gain_low_r});
            ADDR_GAIN_HIGH: rdata_s = C_S_AXI_DATA_WIDTH'({16'h0, gain_high_r});
            ADDR_FRAME_CNT: rdata_s = C_S_AXI_DATA_WIDTH'(frame_cnt_r);
            ADDR_STATUS:    rdata_s = C_S_AXI_DATA_WIDTH'({31'h0, mismatch_r});
            default:        rdata_s = {C_S_AXI_DATA_WIDTH{1'b0}};
        endcase
    end

    // AXI4-Lite handshakes and the control/status register bank.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            awready_r   <= 1'b0;
            wready_r    <= 1'b0;
            bvalid_r    <= 1'b0;
            arready_r   <= 1'b0;
            rvalid_r    <= 1'b0;
            rdata_r     <= {C_S_AXI_DATA_WIDTH{1'b0}};
            en_r        <= 1'b0;
            phase_sel_r <= 1'b0;
            gain_low_r  <= 16'h7FFF;
            gain_high_r <= 16'h7FFF;
            frame_cnt_r <= 32'h0;
            mismatch_r  <= 1'b0;
        end else begin
            awready_r <= bus.s_axi_awvalid && bus.s_axi_wvalid && !awready_r && !bvalid_r;
            wready_r  <= bus.s_axi_awvalid && bus.s_axi_wvalid && !awready_r && !bvalid_r;
            if (wr_en_s)                bvalid_r <= 1'b1;
            else if (bus.s_axi_bready)  bvalid_r <= 1'b0;
            arready_r <= bus.s_axi_arvalid && !arready_r && !rvalid_r;
            if (rd_en_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rdata_s;
            end else if (bus.s_axi_rready) begin
                rvalid_r <= 1'b0;
            end
            if (wr_en_s) begin
                case (bus.s_axi_awaddr)
                    ADDR_CTRL: begin
                        en_r        <= bus.s_axi_wdata[0];
                        phase_sel_r <= bus.s_axi_wdata[1];
                    end
                    ADDR_GAIN_LOW:  gain_low_r  <= bus.s_axi_wdata[15:0];
                    ADDR_GAIN_HIGH: gain_high_r <= bus.s_axi_wdata[15:0];
                    default: ;
                endcase
            end
            if (frame_clr_s)
                frame_cnt_r <= 32'h0;
            else if (m_tvalid_r && bus.m_axis_tready && m_tlast_r)
                frame_cnt_r <= frame_cnt_r + 32'h1;
            if (fire_s && (bus.s_axis_low_tlast != bus.s_axis_high_tlast))
                mismatch_r <= 1'b1;
            else if (status_clr_s)
                mismatch_r <= 1'b0;
        end
    end

    assign bus.s_axis_low_tready  = join_ready_s;
    assign bus.s_axis_high_tready = join_ready_s;
    assign bus.m_axis_tdata       = m_tdata_r;
    assign bus.m_axis_tvalid      = m_tvalid_r;
    assign bus.m_axis_tuser       = m_tuser_r;
    assign bus.m_axis_tlast       = m_tlast_r;
    assign bus.s_axi_awready      = awready_r;
    assign bus.s_axi_wready       = wready_r;
    assign bus.s_axi_bvalid       = bvalid_r;
    assign bus.s_axi_bresp        = 2'b00;
    assign bus.s_axi_arready      = arready_r;
    assign bus.s_axi_rvalid       = rvalid_r;
    assign bus.s_axi_rdata        = rdata_r;
    assign bus.s_axi_rresp        = 2'b00;
endmodule

// File: tb/tb_qmf_subband_decim_axis.sv
// Scoreboard bench for qmf_subband_decim_axis: a reference model of pair selection,
// gain and frame marking queues the expected beats as input pairs are accepted.
module tb_qmf_subband_decim_axis;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    qmf_subband_decim_axis_if #(.C_S_AXI_ADDR_WIDTH(12), .C_S_AXI_DATA_WIDTH(32)) bus ();

    qmf_subband_decim_axis #(.C_S_AXI_ADDR_WIDTH(12), .C_S_AXI_DATA_WIDTH(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model state, configured by the test sequence
    logic        en_m = 1'b0, sel_m = 1'b0, phase_m = 1'b0, pending_m = 1'b0;
    logic [15:0] gl_m = 16'h7FFF, gh_m = 16'h7FFF;
    logic [33:0] sb[$];
    int          beat_cyc[$];
    int          keep_cyc[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_scale(input logic [15:0] x, input logic [15:0] g);
        longint p;
        p = longint'($signed(x)) * longint'($signed(g));
        p = p >>> 15;
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    // Monitor: score output beats, check stall stability, and feed accepted pairs to the model.
    initial begin
        logic        prev_stall;
        logic [33:0] held, exp_beat;
        prev_stall = 1'b0;
        held = 34'h0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                sb.delete();
                phase_m = 1'b0;
                pending_m = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check_val("hold_valid", bus.m_axis_tvalid, 1);
                    check_val("hold_beat", {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata}, held);
                end
                prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
                held = {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata};
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    beat_cyc.push_back(cyc);
                    check_val("beat_expected", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        exp_beat = sb.pop_front();
                        check_val("beat", {bus.m_axis_tuser, bus.m_axis_tlast, bus.m_axis_tdata}, exp_beat);
                    end
                end
                if (bus.s_axis_low_tvalid && bus.s_axis_high_tvalid && bus.s_axis_low_tready) begin
                    if (!en_m) begin
                        phase_m = 1'b0;
                    end else begin
                        if (phase_m == sel_m) begin
                            keep_cyc.push_back(cyc);
                            sb.push_back({1'b0, 1'b0, ref_scale(bus.s_axis_low_tdata[31:16], gl_m),
                                          ref_scale(bus.s_axis_low_tdata[15:0], gl_m)});
                            sb.push_back({1'b1, bus.s_axis_low_tlast | pending_m,
                                          ref_scale(bus.s_axis_high_tdata[31:16], gh_m),
                                          ref_scale(bus.s_axis_high_tdata[15:0], gh_m)});
                            pending_m = 1'b0;
                        end else if (bus.s_axis_low_tlast) begin
                            if (sb.size() != 0) sb[sb.size()-1][32] = 1'b1;
                            else pending_m = 1'b1;
                        end
                        phase_m = bus.s_axis_low_tlast ? 1'b0 : ~phase_m;
                    end
                end
            end
        end
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
        int n;
        bus.s_axi_awaddr = a; bus.s_axi_wdata = d;
        bus.s_axi_awvalid = 1'b1; bus.s_axi_wvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.s_axi_awready && n < 20) begin @(negedge clk); n++; end
        check_val("awready", bus.s_axi_awready, 1);
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.s_axi_bvalid && n < 20) begin @(negedge clk); n++; end
        check_val("bvalid", bus.s_axi_bvalid, 1);
        check_val("bresp", bus.s_axi_bresp, 0);
        bus.s_axi_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_bready = 1'b0;
    endtask

    task automatic reg_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        int n;
        bus.s_axi_araddr = a; bus.s_axi_arvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.s_axi_arready && n < 20) begin @(negedge clk); n++; end
        check_val("arready", bus.s_axi_arready, 1);
        @(posedge clk); #1;
        bus.s_axi_arvalid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
        check_val("rvalid", bus.s_axi_rvalid, 1);
        check_val("rresp", bus.s_axi_rresp, 0);
        check_val(tag, bus.s_axi_rdata, exp);
        bus.s_axi_rready = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_rready = 1'b0;
    endtask

    task automatic send_pair(input logic [31:0] lo, input logic [31:0] hi, input logic llast, input logic hlast);
        int n;
        bus.s_axis_low_tdata = lo;   bus.s_axis_low_tlast = llast;   bus.s_axis_low_tvalid = 1'b1;
        bus.s_axis_high_tdata = hi;  bus.s_axis_high_tlast = hlast;  bus.s_axis_high_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.s_axis_low_tready && n < 200) begin @(negedge clk); n++; end
        check_val("in_ready", bus.s_axis_low_tready, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        bus.s_axis_low_tvalid = 1'b0;  bus.s_axis_high_tvalid = 1'b0;
        bus.s_axis_low_tlast = 1'b0;   bus.s_axis_high_tlast = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((sb.size() != 0 || bus.m_axis_tvalid) && n < 500) begin @(negedge clk); n++; end
        check_val("drain", sb.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic stream_done;
        bus.s_axis_low_tdata = 32'h0;  bus.s_axis_high_tdata = 32'h0;
        idle_inputs();
        bus.m_axis_tready = 1'b1;
        bus.s_axi_awaddr = 12'h0; bus.s_axi_awvalid = 1'b0; bus.s_axi_wdata = 32'h0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b0;  bus.s_axi_araddr = 12'h0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        // reset state
        @(negedge clk);
        check_val("rst_tvalid", bus.m_axis_tvalid, 0);
        check_val("rst_tdata", bus.m_axis_tdata, 0);
        check_val("rst_awready", bus.s_axi_awready, 0);
        reg_check("rst_ctrl", 12'h00, 32'h0);
        reg_check("rst_gain_low", 12'h04, 32'h7FFF);
        reg_check("rst_gain_high", 12'h08, 32'h7FFF);
        reg_check("rst_frame_cnt", 12'h0C, 32'h0);
        reg_check("rst_status", 12'h10, 32'h0);
        axi_write(12'h20, 32'hFFFF_FFFF);
        reg_check("unmapped_read", 12'h20, 32'h0);
        reg_check("unmapped_write", 12'h00, 32'h0);

        // pairs 1..8, phase_sel=0: pairs 1,3,5,7 kept back to back
        axi_write(12'h00, 32'h1); en_m = 1'b1; sel_m = 1'b0;
        beat_cyc.delete(); keep_cyc.delete();
        for (int k = 1; k <= 8; k++) send_pair({16'(k*1000), 16'(k*1000)}, {16'(k*1000), 16'(k*1000)}, 1'b0, 1'b0);
        idle_inputs();
        wait_drain();
        check_val("beat_count", beat_cyc.size(), 8);
        if (beat_cyc.size() == 8) check_val("throughput", beat_cyc[7] - beat_cyc[0], 7);
        if (keep_cyc.size() != 0 && beat_cyc.size() != 0) check_val("latency", beat_cyc[0] - keep_cyc[0], 1);

        // phase_sel=1, half gain on the high band
        axi_write(12'h08, 32'h4000); gh_m = 16'h4000;
        axi_write(12'h00, 32'h3);    sel_m = 1'b1;
        for (int k = 1; k <= 4; k++) send_pair({16'(k*100), 16'(k*100)}, 32'h2000_2000, 1'b0, 1'b0);
        idle_inputs();
        wait_drain();

        // saturation corners with gain -1.0
        axi_write(12'h04, 32'h8000); gl_m = 16'h8000;
        axi_write(12'h00, 32'h1);    sel_m = 1'b0;
        send_pair(32'h7FFF_8000, 32'h0123_FEDC, 1'b0, 1'b0);
        send_pair(32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0);
        idle_inputs();
        wait_drain();

        // tlast on dropped pair 4 moves to pair 3's high beat, next frame restarts at phase 0
        axi_write(12'h04, 32'h7FFF); gl_m = 16'h7FFF;
        axi_write(12'h08, 32'h7FFF); gh_m = 16'h7FFF;
        axi_write(12'h0C, 32'hDEAD_BEEF);
        for (int k = 1; k <= 6; k++) send_pair({16'(k*7), 16'(k*9)}, {16'(k*11), 16'(k*13)}, k == 4, k == 4);
        idle_inputs();
        wait_drain();
        reg_check("frame_cnt_one", 12'h0C, 32'h1);

        // random downstream stalls
        stream_done = 1'b0;
        fork
            begin
                for (int k = 1; k <= 16; k++) send_pair($urandom, $urandom, k == 8, k == 8);
                idle_inputs();
                stream_done = 1'b1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk); #1;
                    bus.m_axis_tready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.m_axis_tready = 1'b1;
        wait_drain();
        reg_check("frame_cnt_two", 12'h0C, 32'h2);

        // tlast disagreement between bands
        reg_check("status_clean", 12'h10, 32'h0);
        send_pair(32'h0000_0010, 32'h0000_0020, 1'b1, 1'b0);
        idle_inputs();
        wait_drain();
        reg_check("status_mismatch", 12'h10, 32'h1);
        axi_write(12'h10, 32'h1);
        reg_check("status_cleared", 12'h10, 32'h0);
        send_pair(32'h0000_0030, 32'h0000_0040, 1'b1, 1'b0);
        idle_inputs();
        wait_drain();

        // reset while the low beat is stalled
        bus.m_axis_tready = 1'b0;
        send_pair(32'h0005_0005, 32'h0006_0006, 1'b0, 1'b0);
        idle_inputs();
        @(negedge clk);
        check_val("pre_rst_tvalid", bus.m_axis_tvalid, 1);
        check_val("pre_rst_tuser", bus.m_axis_tuser, 0);
        #1 rstn = 1'b0;
        en_m = 1'b0; sel_m = 1'b0; gl_m = 16'h7FFF; gh_m = 16'h7FFF;
        @(negedge clk);
        check_val("post_rst_tvalid", bus.m_axis_tvalid, 0);
        check_val("post_rst_tdata", bus.m_axis_tdata, 0);
        check_val("post_rst_tuser", bus.m_axis_tuser, 0);
        check_val("post_rst_tlast", bus.m_axis_tlast, 0);
        @(posedge clk); #1;
        rstn = 1'b1;
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("no_beat_after_rst", bus.m_axis_tvalid, 0);
        end
        reg_check("rst2_ctrl", 12'h00, 32'h0);
        reg_check("rst2_gain_high", 12'h08, 32'h7FFF);
        reg_check("rst2_frame_cnt", 12'h0C, 32'h0);
        reg_check("rst2_status", 12'h10, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
